// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I load/store funct3 encodings, LSU state type and
// small decode helpers shared by the LSU and its alignment datapath.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Stores only come in signed-size flavours; loads add the unsigned ones.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Natural alignment: halfwords on even bytes, words on 4-byte boundaries.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational size/offset datapath -- byte enables,
// store lane replication, load lane extraction with sign/zero extension,
// and the misaligned/illegal-funct3 error flag.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign err    = !funct3_legal(we, funct3) || misaligned(funct3, addr_lo);

    // Byte enables and store-data replication by access size
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{lane_b[7]}}, lane_b};
            F3_H:    rdata_ext = {{16{lane_h[15]}}, lane_h};
            F3_W:    rdata_ext = rdata;
            F3_BU:   rdata_ext = {24'd0, lane_b};
            F3_HU:   rdata_ext = {16'd0, lane_h};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit. Accepts one op from execute,
// drives a simple req/gnt + rvalid memory port, and returns a one-cycle
// completion pulse with aligned load data or an error flag.
module lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state;
    logic        op_we;
    logic [2:0]  op_funct3;
    logic [1:0]  op_addr_lo;
    logic [15:0] cnt;

    logic        idle;
    logic        accept;
    logic        timeout;
    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_err;

    assign idle      = (state == ST_IDLE);
    assign req_ready = idle;
    assign accept    = req_valid && idle;
    // >= rather than ==: a grant on the last allowed cycle still lets WAIT time out.
    assign timeout   = (cnt >= CNT_LAST);

    // While idle the aligner decodes the incoming request; afterwards the registered op.
    assign al_we      = idle ? req_we         : op_we;
    assign al_funct3  = idle ? req_funct3     : op_funct3;
    assign al_addr_lo = idle ? req_addr[1:0]  : op_addr_lo;

    lsu_align u_align (
        .we        (al_we),
        .funct3    (al_funct3),
        .addr_lo   (al_addr_lo),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .err       (al_err)
    );

    // Op sequencing: accept, hold the memory request until granted, collect load data, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= ST_IDLE;
            op_we      <= 1'b0;
            op_funct3  <= '0;
            op_addr_lo <= '0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_rd     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_we      <= req_we;
                        op_funct3  <= req_funct3;
                        op_addr_lo <= req_addr[1:0];
                        rsp_rd     <= req_rd;
                        rsp_data   <= '0;
                        cnt        <= '0;
                        if (al_err) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            rsp_err   <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= req_we ? al_wdata : '0;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 16'd1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op_we) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else if (mem_rvalid) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= al_rdata;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (mem_rvalid) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= al_rdata;
                    end else if (timeout) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized scoreboard bench for the LSU. Stimulus pushes the
// expected completion into a queue; an independent monitor pops and compares
// on every rsp_valid. A second instance with a short timeout covers aborts.
module tb_lsu;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;

    logic        t_req_valid, t_req_ready, t_req_we;
    logic [2:0]  t_req_funct3;
    logic [31:0] t_req_addr, t_req_wdata;
    logic [4:0]  t_req_rd;
    logic        t_mem_req, t_mem_we;
    logic [31:0] t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;
    logic        t_mem_gnt, t_mem_rvalid;
    logic [31:0] t_mem_rdata;
    logic        t_rsp_valid, t_rsp_err;
    logic [31:0] t_rsp_data;
    logic [4:0]  t_rsp_rd;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );

    lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(t_req_we),
        .req_funct3(t_req_funct3), .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_rd(t_req_rd),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
        .mem_wdata(t_mem_wdata), .mem_gnt(t_mem_gnt), .mem_rvalid(t_mem_rvalid), .mem_rdata(t_mem_rdata),
        .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_rd(t_rsp_rd), .rsp_err(t_rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: derives the memory-side and response-side view of one op
    // from size/offset arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic err, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] rv);
        int          size;
        int          off;
        logic        legal;
        logic [31:0] lane;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        err   = !legal || ((off % size) != 0);
        be    = err ? 4'd0 : 4'(((1 << size) - 1) << off);
        lane  = rdata >> (8 * off);
        wd    = wdata;
        rv    = rdata;
        if (size == 1) begin
            wd = 32'(wdata[7:0]) * 32'h0101_0101;
            rv = lane & 32'hFF;
            if (f3 == 3'd0 && rv[7]) rv = rv | 32'hFFFF_FF00;
        end else if (size == 2) begin
            wd = 32'(wdata[15:0]) * 32'h0001_0001;
            rv = lane & 32'hFFFF;
            if (f3 == 3'd1 && rv[15]) rv = rv | 32'hFFFF_0000;
        end
        if (err || we) rv = 32'd0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   32'(mem_req),   32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  mem_addr,       32'd0);
        check({tag, "_mem_be"},    32'(mem_be),    32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_rsp_data"},  rsp_data,       32'd0);
        check({tag, "_rsp_rd"},    32'(rsp_rd),    32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Issue one op and play the memory side. Entered and left just after a rising edge.
    // gnt_dly: REQ cycles before the grant; rv_dly: WAIT cycles to rvalid (0 = with grant).
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly);
        exp_t        e;
        logic        err;
        logic [3:0]  ebe;
        logic [31:0] ewd, erv;
        int          n;
        model(we, f3, addr, wdata, rdata, err, ebe, ewd, erv);
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before_op", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        e.rd = rd; e.data = erv; e.err = err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        if (err) begin
            @(negedge clk);
            check("err_no_mem_req", 32'(mem_req), 32'd0);
            check("err_rsp_latency", 32'(rsp_valid), 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                mem_gnt = 1'b1; mem_rvalid = 1'b1;
            end
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                @(negedge clk);
                check("req_mem_req", 32'(mem_req), 32'd1);
                check("req_mem_we", 32'(mem_we), 32'(we));
                check("req_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check("req_mem_be", 32'(mem_be), 32'(ebe));
                if (we) check("req_mem_wdata", mem_wdata, ewd);
                check("req_no_early_rsp", 32'(rsp_valid), 32'd0);
                if (i == gnt_dly) begin
                    mem_gnt = 1'b1;
                    if (!we && rv_dly == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = rdata;
                    end
                end
                @(posedge clk); #1;
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            if (!we && rv_dly > 0) begin
                for (int i = 1; i <= rv_dly; i++) begin
                    @(negedge clk);
                    check("wait_mem_req_low", 32'(mem_req), 32'd0);
                    check("wait_no_early_rsp", 32'(rsp_valid), 32'd0);
                    if (i == rv_dly) begin
                        mem_rvalid = 1'b1; mem_rdata = rdata;
                    end
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0; mem_rdata = $urandom;
                end
            end
            @(negedge clk);
            check("rsp_latency", 32'(rsp_valid), 32'd1);
            check("rsp_mem_req_low", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        check("req_ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual rd=%0d data=0x%08h err=%0b required=none",
                         rsp_rd, rsp_data, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rd", 32'(rsp_rd), 32'(e.rd));
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  lf [5];
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
        rst_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = '0; t_req_addr = '0;
        t_req_wdata = '0; t_req_rd = '0;
        t_mem_gnt = 1'b0; t_mem_rvalid = 1'b0; t_mem_rdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        do_op(1'b0, 3'd0, 32'h0000_1003, 32'h0, 5'd1, 32'h80AA_BBCC, 0, 1);   // LB sign-extend
        do_op(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 5'd2, 32'h0, 0, 0);   // SH upper half
        do_op(1'b0, 3'd2, 32'h0000_1001, 32'h0, 5'd3, 32'h0, 0, 0);           // LW misaligned
        do_op(1'b0, 3'd5, 32'h0000_0010, 32'h0, 5'd4, 32'h0000_F00D, 3, 2);   // LHU slow memory
        do_op(1'b0, 3'd6, 32'h0000_0020, 32'h0, 5'd5, 32'h0, 0, 0);           // illegal funct3
        do_op(1'b1, 3'd4, 32'h0000_0024, 32'h55, 5'd6, 32'h0, 0, 0);          // store funct3 100
        do_op(1'b0, 3'd4, 32'h0000_0031, 32'h0, 5'd7, 32'h1234_8F56, 1, 0);   // LBU same-cycle rvalid
        do_op(1'b1, 3'd0, 32'h0000_0043, 32'hDEAD_BEA5, 5'd8, 32'h0, 2, 0);   // SB lane 3

        // Randomized ops, mostly legal and aligned
        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) != 0)
                f3 = we ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) addr[0] = 1'b0;
                if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            end
            do_op(we, f3, addr, $urandom, 5'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
                @(posedge clk); #1;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
        end

        // Reset in the middle of WAIT, then a stray late rvalid
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd4; req_addr = 32'h0000_0040; req_rd = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_pre_wait_mem_req", 32'(mem_req), 32'd0);
        check("rst_pre_wait_rsp_rd", 32'(rsp_rd), 32'd9);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_wait");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00EE;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_no_rsp", 32'(rsp_valid), 32'd0);
        check("late_rvalid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        do_op(1'b0, 3'd2, 32'h0000_0080, 32'h0, 5'd10, 32'hCAFE_F00D, 1, 1);

        // Short-timeout instance: grant never arrives
        t_req_valid = 1'b1; t_req_we = 1'b0; t_req_funct3 = 3'd2; t_req_addr = 32'h100; t_req_rd = 5'd3;
        @(posedge clk); #1;
        t_req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("to_req_mem_req", 32'(t_mem_req), 32'd1);
            check("to_req_no_rsp", 32'(t_rsp_valid), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check("to_req_rsp_valid", 32'(t_rsp_valid), 32'd1);
        check("to_req_rsp_err", 32'(t_rsp_err), 32'd1);
        check("to_req_mem_req_dropped", 32'(t_mem_req), 32'd0);
        check("to_req_rsp_rd", 32'(t_rsp_rd), 32'd3);
        check("to_req_rsp_data", t_rsp_data, 32'd0);
        @(posedge clk); #1;
        check("to_req_ready_after", 32'(t_req_ready), 32'd1);

        // Short-timeout instance: granted at once, rvalid never arrives
        t_req_valid = 1'b1; t_req_funct3 = 3'd0; t_req_addr = 32'h203; t_req_rd = 5'd12;
        @(posedge clk); #1;
        t_req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("to_wait_mem_req", 32'(t_mem_req), (i == 1) ? 32'd1 : 32'd0);
            check("to_wait_no_rsp", 32'(t_rsp_valid), 32'd0);
            t_mem_gnt = (i == 1);
            @(posedge clk); #1;
            t_mem_gnt = 1'b0;
        end
        @(negedge clk);
        check("to_wait_rsp_valid", 32'(t_rsp_valid), 32'd1);
        check("to_wait_rsp_err", 32'(t_rsp_err), 32'd1);
        check("to_wait_rsp_rd", 32'(t_rsp_rd), 32'd12);
        @(posedge clk); #1;
        check("to_wait_ready_after", 32'(t_req_ready), 32'd1);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before abort; legal range 1..65535.
REQ-002 Reset: asynchronous, active-low. Clock: single clock; all state updates on its rising edge.
REQ-003 clk  in  1  sole clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  execute stage presents a memory op.
REQ-006 req_ready  out  1  LSU can accept a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32I size/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; stores 000/001/010).
REQ-009 req_addr  in  32  effective address, the ALU add result.
REQ-010 req_wdata  in  32  store data (rs2).
REQ-011 req_rd  in  5  destination register tag, passed through.
REQ-012 mem_req  out  1  memory request strobe.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_addr  out  32  word address, bits [1:0] forced 0.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_gnt  in  1  memory accepted the request.
REQ-018 mem_rvalid  in  1  load data valid.
REQ-019 mem_rdata  in  32  load data word.
REQ-020 rsp_valid  out  1  one-cycle completion pulse to writeback.
REQ-021 rsp_data  out  32  aligned, extended load result; 0 for stores and errors.
REQ-022 rsp_rd  out  5  tag of the completed op.
REQ-023 rsp_err  out  1  misaligned, illegal funct3, or timeout.

Function
REQ-024 FSM states: IDLE, REQ, WAIT, RESP; req_ready = (state == IDLE).
REQ-025 Acceptance (req_valid & req_ready) in cycle T registers the op and sets rsp_rd = req_rd.
REQ-026 Misaligned access (halfword with addr[0] = 1; word with addr[1:0] != 0) or illegal funct3: no mem_req, go to RESP, rsp_valid=1 with rsp_err=1 in T+1.
REQ-027 Legal op: enter REQ; mem_req=1 from T+1, with address/be/wdata held stable until mem_gnt.
REQ-028 Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-029 Store data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-030 Store: mem_gnt in REQ -> RESP; rsp_valid one cycle later.
REQ-031 Load: mem_gnt in REQ -> WAIT; mem_rvalid in WAIT -> RESP, capture lane-selected data; rsp_valid one cycle later.
REQ-032 mem_gnt and mem_rvalid in the same REQ cycle: the load completes directly; WAIT is skipped.
REQ-033 Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-034 RESP lasts exactly one cycle, then returns to IDLE; req_ready=1 the cycle after rsp_valid.
REQ-035 A 16-bit cycle counter clears on acceptance and increments in REQ/WAIT; reaching TIMEOUT_CYCLES -> RESP with rsp_err=1, mem_req dropped.
REQ-036 mem_gnt/mem_rvalid received in IDLE or RESP are ignored.

Reset
REQ-037 Reset asserted (any state, including mid-WAIT): state=IDLE and mem_req=mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rsp_valid=rsp_err=0, rsp_data=0, rsp_rd=0, counter=0; req_ready=1 after deassertion.

Structure
REQ-038 Shared package riscv_pkg holds the funct3 load/store encodings and the LSU state enum.
REQ-039 Combinational sub-module lsu_align computes mem_be, store replication and load extraction/extension; the FSM lives in lsu.

Verification
REQ-040 LB addr 0x0000_1003, mem_rdata 0x80AA_BBCC -> mem_be 1000, rsp_data 0xFFFF_FF80, rsp_err 0.
REQ-041 SH addr 0x0000_2002, wdata 0x1234_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_addr 0x0000_2000, rsp_valid one cycle after gnt.
REQ-042 LW addr 0x0000_1001 -> no mem_req, rsp_valid & rsp_err in T+1, rsp_data 0.
REQ-043 LHU addr 0x10 with gnt delayed 3 cycles and rvalid 2 cycles later, mem_rdata 0x0000_F00D -> request held stable throughout, rsp_data 0x0000_F00D.
REQ-044 TIMEOUT_CYCLES=4 with mem_gnt never asserted -> rsp_err=1 after 4 REQ cycles, then IDLE.
REQ-045 rst_n pulsed low during WAIT, then a late rvalid -> outputs at reset values, no rsp_valid, next op completes normally.
